// File: rtl/dm_pkg.sv
// Shared types for the data-memory arbiter: FSM encoding, default widths
// and the per-requester beat descriptor.
package dm_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 3;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic                  lock;
    logic [31:0]           addr;
    logic [DEF_DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/dm_rr_pick.sv
// Combinational 2-way round-robin picker; a locked state restricts the
// grant to the lock owner.
module dm_rr_pick
  import dm_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  state_t     state,
  output logic [1:0] grant
);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = 2'b00;
    unique case (state)
      ARB: begin
        if (valid == 2'b11) grant = last_grant ? 2'b01 : 2'b10;
        else                grant = valid;
      end
      LOCK0:   grant = {1'b0, valid[0]};
      LOCK1:   grant = {valid[1], 1'b0};
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of the 8-word data memory,
// with locked bursts and a registered single-cycle response per beat.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic              req0_lock,
  input  logic [31:0]       req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic              req1_lock,
  input  logic [31:0]       req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic              MemWrite,
  output logic              MemRead,
  output logic [31:0]       write_address,
  output logic [31:0]       read_address,
  output logic [DATA_W-1:0] Write_data,
  input  logic [DATA_W-1:0] MemData_out
);

  state_t      state, state_nxt;
  logic        last_grant;
  logic [3:0]  burst_cnt, burst_nxt;
  logic [1:0]  grant;
  logic        acc0, acc1, in_range;
  req_t        r0, r1, sel;
  logic [31:0] mem_index;

  dm_rr_pick u_pick (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .state      (state),
    .grant      (grant)
  );

  assign req0_ready = grant[0] & ~reset;
  assign req1_ready = grant[1] & ~reset;
  assign acc0       = req0_valid & req0_ready;
  assign acc1       = req1_valid & req1_ready;

  assign r0 = '{req0_valid, req0_we, req0_lock, req0_addr, req0_wdata};
  assign r1 = '{req1_valid, req1_we, req1_lock, req1_addr, req1_wdata};

  // sel.valid doubles as "a beat was accepted this cycle".
  always_comb begin
    sel = '0;
    if (acc1)      sel = r1;
    else if (acc0) sel = r0;
  end

  assign in_range  = (sel.addr[31:ADDR_W] == '0);
  assign mem_index = {{(32-ADDR_W){1'b0}}, sel.addr[ADDR_W-1:0]};

  always_comb begin
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    write_address = '0;
    read_address  = '0;
    Write_data    = '0;
    if (sel.valid && in_range) begin
      if (sel.we) begin
        MemWrite      = 1'b1;
        write_address = mem_index;
        Write_data    = sel.wdata;
      end else begin
        MemRead      = 1'b1;
        read_address = mem_index;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    unique case (state)
      ARB: begin
        if (sel.valid && sel.lock) begin
          state_nxt = acc1 ? LOCK1 : LOCK0;
          burst_nxt = 4'd1;
        end
      end
      LOCK0, LOCK1: begin
        if (sel.valid && sel.lock && (burst_cnt + 4'd1 < 4'(MAX_BURST))) begin
          burst_nxt = burst_cnt + 4'd1;
        end else begin
          // Owner dropped valid, released the lock, or hit the burst limit.
          state_nxt = ARB;
          burst_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = ARB;
        burst_nxt = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      last_grant <= 1'b1;
      burst_cnt  <= 4'd0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (sel.valid) last_grant <= acc1;
      rsp0_valid <= acc0;
      rsp0_err   <= acc0 & ~in_range;
      rsp0_rdata <= (acc0 && in_range && !sel.we) ? MemData_out : '0;
      rsp1_valid <= acc1;
      rsp1_err   <= acc1 & ~in_range;
      rsp1_rdata <= (acc1 && in_range && !sel.we) ? MemData_out : '0;
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with an 8-word behavioural memory attached.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_we, req0_lock;
  logic [31:0] req0_addr, req0_wdata;
  logic        req1_valid, req1_we, req1_lock;
  logic [31:0] req1_addr, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        MemWrite, MemRead;
  logic [31:0] write_address, read_address, Write_data, MemData_out;
  logic [31:0] mem [8];

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_lock(req0_lock),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_lock(req1_lock),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .write_address(write_address), .read_address(read_address),
    .Write_data(Write_data), .MemData_out(MemData_out)
  );

  assign MemData_out = mem[read_address[2:0]];
  always @(posedge clk) if (MemWrite) mem[write_address[2:0]] <= Write_data;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    req0_valid = 0; req0_we = 0; req0_lock = 0; req0_addr = 0; req0_wdata = 0;
    req1_valid = 0; req1_we = 0; req1_lock = 0; req1_addr = 0; req1_wdata = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1; tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    req0_valid = 1; req0_we = 1; req0_addr = 32'd2; req0_wdata = 32'hFFFF_0000;
    settle();
    n_cmp++; if (req0_ready !== 1'b0) begin n_mis++; $display("FAIL rst_ready0: got %b want 0", req0_ready); end
    n_cmp++; if (MemWrite !== 1'b0) begin n_mis++; $display("FAIL rst_memwrite: got %b want 0", MemWrite); end
    tick();
    n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_mis++; $display("FAIL rst_rsp_valid: got %b%b want 00", rsp1_valid, rsp0_valid); end
    do_reset();
  endtask

  task automatic test_write_read();
    do_reset();
    req0_valid = 1; req0_we = 1; req0_addr = 32'd5; req0_wdata = 32'hDEAD_BEEF;
    settle();
    n_cmp++; if (req0_ready !== 1'b1) begin n_mis++; $display("FAIL wr_ready0: got %b want 1", req0_ready); end
    n_cmp++; if (MemWrite !== 1'b1 || MemRead !== 1'b0) begin n_mis++; $display("FAIL wr_mem_en: got w=%b r=%b want w=1 r=0", MemWrite, MemRead); end
    n_cmp++; if (write_address !== 32'd5) begin n_mis++; $display("FAIL wr_addr: got %0d want 5", write_address); end
    n_cmp++; if (Write_data !== 32'hDEAD_BEEF) begin n_mis++; $display("FAIL wr_data: got %h want deadbeef", Write_data); end
    tick();
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'd0 || rsp0_err !== 1'b0) begin n_mis++; $display("FAIL wr_rsp: got v=%b d=%h e=%b want v=1 d=0 e=0", rsp0_valid, rsp0_rdata, rsp0_err); end
    req0_we = 0;
    settle();
    n_cmp++; if (MemRead !== 1'b1 || MemWrite !== 1'b0 || read_address !== 32'd5) begin n_mis++; $display("FAIL rd_mem: got r=%b w=%b a=%0d want r=1 w=0 a=5", MemRead, MemWrite, read_address); end
    tick();
    idle();
    n_cmp++; if (rsp0_valid !== 1'b1 || rsp0_rdata !== 32'hDEAD_BEEF || rsp0_err !== 1'b0) begin n_mis++; $display("FAIL rd_rsp: got v=%b d=%h e=%b want v=1 d=deadbeef e=0", rsp0_valid, rsp0_rdata, rsp0_err); end
    tick();
    n_cmp++; if (rsp0_valid !== 1'b0) begin n_mis++; $display("FAIL rsp_pulse: got %b want 0", rsp0_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    req0_valid = 1; req0_addr = 32'd2;
    req1_valid = 1; req1_addr = 32'd3;
    for (int i = 0; i < 4; i++) begin
      logic exp0;
      exp0 = (i % 2 == 0);
      settle();
      n_cmp++; if (req0_ready !== exp0 || req1_ready !== !exp0) begin n_mis++; $display("FAIL rr_grant%0d: got %b%b want %b%b", i, req1_ready, req0_ready, !exp0, exp0); end
      tick();
      n_cmp++; if (rsp0_valid !== exp0 || rsp1_valid !== !exp0) begin n_mis++; $display("FAIL rr_rsp%0d: got %b%b want %b%b", i, rsp1_valid, rsp0_valid, !exp0, exp0); end
      if (exp0) begin
        n_cmp++; if (rsp0_rdata !== 32'h0000_1002) begin n_mis++; $display("FAIL rr_rdata0_%0d: got %h want 00001002", i, rsp0_rdata); end
      end else begin
        n_cmp++; if (rsp1_rdata !== 32'h0000_1003) begin n_mis++; $display("FAIL rr_rdata1_%0d: got %h want 00001003", i, rsp1_rdata); end
      end
    end
    idle();
  endtask

  task automatic test_lock_burst();
    do_reset();
    req0_valid = 1; req0_lock = 1; req0_addr = 32'd1;
    req1_valid = 1; req1_addr = 32'd4;
    for (int i = 0; i < 4; i++) begin
      settle();
      n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_mis++; $display("FAIL burst_beat%0d: got %b%b want 01", i, req1_ready, req0_ready); end
      tick();
    end
    settle();
    n_cmp++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin n_mis++; $display("FAIL burst_release: got %b%b want 10", req1_ready, req0_ready); end
    tick();
    n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h0000_1004) begin n_mis++; $display("FAIL burst_rsp1: got v=%b d=%h want v=1 d=00001004", rsp1_valid, rsp1_rdata); end
    n_cmp++; if (req0_ready !== 1'b1) begin n_mis++; $display("FAIL burst_rr_back: got %b want 1", req0_ready); end
    idle();
  endtask

  task automatic test_out_of_range();
    do_reset();
    req1_valid = 1; req1_we = 1; req1_addr = 32'h9; req1_wdata = 32'hBAD0_BAD0;
    settle();
    n_cmp++; if (req1_ready !== 1'b1) begin n_mis++; $display("FAIL oor_ready1: got %b want 1", req1_ready); end
    n_cmp++; if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin n_mis++; $display("FAIL oor_mem_en: got w=%b r=%b want 0 0", MemWrite, MemRead); end
    tick();
    n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_err !== 1'b1 || rsp1_rdata !== 32'd0) begin n_mis++; $display("FAIL oor_wr_rsp: got v=%b e=%b d=%h want 1 1 0", rsp1_valid, rsp1_err, rsp1_rdata); end
    req1_we = 0; req1_addr = 32'h100;
    settle();
    n_cmp++; if (MemRead !== 1'b0) begin n_mis++; $display("FAIL oor_rd_en: got %b want 0", MemRead); end
    tick();
    n_cmp++; if (rsp1_err !== 1'b1 || rsp1_rdata !== 32'd0) begin n_mis++; $display("FAIL oor_rd_rsp: got e=%b d=%h want e=1 d=0", rsp1_err, rsp1_rdata); end
    req1_addr = 32'd1;
    settle();
    n_cmp++; if (MemRead !== 1'b1 || read_address !== 32'd1) begin n_mis++; $display("FAIL oor_readback_mem: got r=%b a=%0d want r=1 a=1", MemRead, read_address); end
    tick();
    n_cmp++; if (rsp1_rdata !== 32'h0000_1001 || rsp1_err !== 1'b0) begin n_mis++; $display("FAIL oor_unchanged: got d=%h e=%b want 00001001 e=0", rsp1_rdata, rsp1_err); end
    idle();
  endtask

  task automatic test_lock_drop();
    do_reset();
    req0_valid = 1; req0_lock = 1; req0_addr = 32'd0;
    req1_valid = 1; req1_addr = 32'd7;
    settle();
    n_cmp++; if (req0_ready !== 1'b1) begin n_mis++; $display("FAIL drop_first: got %b want 1", req0_ready); end
    tick();
    settle();
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_mis++; $display("FAIL drop_locked: got %b%b want 01", req1_ready, req0_ready); end
    tick();
    req0_valid = 0;
    settle();
    n_cmp++; if (req1_ready !== 1'b0) begin n_mis++; $display("FAIL drop_nogrant: got %b want 0", req1_ready); end
    tick();
    n_cmp++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin n_mis++; $display("FAIL drop_norsp: got %b%b want 00", rsp1_valid, rsp0_valid); end
    n_cmp++; if (req1_ready !== 1'b1) begin n_mis++; $display("FAIL drop_req1_grant: got %b want 1", req1_ready); end
    tick();
    n_cmp++; if (rsp1_valid !== 1'b1 || rsp1_rdata !== 32'h0000_1007) begin n_mis++; $display("FAIL drop_rsp1: got v=%b d=%h want 1 00001007", rsp1_valid, rsp1_rdata); end
    idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req1_valid = 1; req1_lock = 1; req1_addr = 32'd6;
    settle();
    n_cmp++; if (req1_ready !== 1'b1) begin n_mis++; $display("FAIL mid_first: got %b want 1", req1_ready); end
    tick();
    n_cmp++; if (rsp1_valid !== 1'b1) begin n_mis++; $display("FAIL mid_rsp_before: got %b want 1", rsp1_valid); end
    reset = 1;
    req1_we = 1; req1_wdata = 32'h0000_0055;
    req0_valid = 1; req0_addr = 32'd6;
    settle();
    n_cmp++; if (req1_ready !== 1'b0 || req0_ready !== 1'b0) begin n_mis++; $display("FAIL mid_ready: got %b%b want 00", req1_ready, req0_ready); end
    n_cmp++; if (MemWrite !== 1'b0 || MemRead !== 1'b0) begin n_mis++; $display("FAIL mid_mem: got w=%b r=%b want 0 0", MemWrite, MemRead); end
    tick();
    reset = 0;
    n_cmp++; if (rsp1_valid !== 1'b0) begin n_mis++; $display("FAIL mid_rsp_drop: got %b want 0", rsp1_valid); end
    settle();
    n_cmp++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin n_mis++; $display("FAIL mid_arb: got %b%b want 01", req1_ready, req0_ready); end
    tick();
    n_cmp++; if (rsp0_rdata !== 32'h0000_1006) begin n_mis++; $display("FAIL mid_nowrite: got %h want 00001006", rsp0_rdata); end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'h1000 + i;
    idle();
    reset = 1;
    tick(); tick();
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_out_of_range();
    test_lock_drop();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
